// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
// Shares one single-port memory between the instruction fetch path and the
// data load/store path. Data requests win by default; after STARVE_LIMIT
// consecutive data grants taken while a fetch waits, the fetch is forced in.
// A flush during a fetch lets the memory transaction finish but swallows
// its response.
//
// Ports:
//   iClk, iRst_n                 clock (rising edge), async active-low reset
//   iInstrValid/iInstrAddress    fetch request
//   iFlush                       discard the in-flight fetch response
//   oInstrReady/oInstrData       fetch completion pulse and fetched word
//   iDataValid/iDataWrite/
//   iDataAddress/iDataWriteData  load/store request
//   oDataReady/oDataReadData     load/store completion pulse and load data
//   oMemValid/oMemWrite/
//   oMemAddress/oMemWriteData    registered memory transaction
//   iMemReady/iMemReadData       memory completion and read data

module memory_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iInstrValid,
    input  logic [ADDR_WIDTH-1:0] iInstrAddress,
    input  logic                  iFlush,
    output logic                  oInstrReady,
    output logic [DATA_WIDTH-1:0] oInstrData,
    input  logic                  iDataValid,
    input  logic                  iDataWrite,
    input  logic [ADDR_WIDTH-1:0] iDataAddress,
    input  logic [DATA_WIDTH-1:0] iDataWriteData,
    output logic                  oDataReady,
    output logic [DATA_WIDTH-1:0] oDataReadData,
    output logic                  oMemValid,
    output logic                  oMemWrite,
    output logic [ADDR_WIDTH-1:0] oMemAddress,
    output logic [DATA_WIDTH-1:0] oMemWriteData,
    input  logic                  iMemReady,
    input  logic [DATA_WIDTH-1:0] iMemReadData
);

    localparam int unsigned           CntWidth = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntWidth-1:0] CntMax   = CntWidth'(STARVE_LIMIT);
    localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);

    typedef enum logic [1:0] {
        StIdle,
        StGntI,
        StGntD
    } state_t;

    state_t                state;
    logic [CntWidth-1:0]   starveCnt;
    logic                  drop;
    logic                  memValid;
    logic                  memWrite;
    logic [ADDR_WIDTH-1:0] memAddress;
    logic [DATA_WIDTH-1:0] memWriteData;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state        <= StIdle;
            starveCnt    <= '0;
            drop         <= 1'b0;
            memValid     <= 1'b0;
            memWrite     <= 1'b0;
            memAddress   <= '0;
            memWriteData <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (iInstrValid && (!iDataValid || starveCnt == CntMax)) begin
                        state        <= StGntI;
                        starveCnt    <= '0;
                        memValid     <= 1'b1;
                        memWrite     <= 1'b0;
                        memAddress   <= iInstrAddress;
                        memWriteData <= '0;
                    end else if (iDataValid) begin
                        state        <= StGntD;
                        memValid     <= 1'b1;
                        memWrite     <= iDataWrite;
                        memAddress   <= iDataAddress;
                        memWriteData <= iDataWriteData;
                        // Only count data wins that actually made a fetch wait.
                        if (iInstrValid && starveCnt != CntMax) begin
                            starveCnt <= starveCnt + CntOne;
                        end
                    end
                end
                StGntI: begin
                    // Sticky so a one-cycle flush pulse still kills a late response.
                    if (iFlush) begin
                        drop <= 1'b1;
                    end
                    if (iMemReady) begin
                        state    <= StIdle;
                        drop     <= 1'b0;
                        memValid <= 1'b0;
                        memWrite <= 1'b0;
                    end
                end
                StGntD: begin
                    if (iMemReady) begin
                        state    <= StIdle;
                        memValid <= 1'b0;
                        memWrite <= 1'b0;
                    end
                end
                default: begin
                    state    <= StIdle;
                    memValid <= 1'b0;
                    memWrite <= 1'b0;
                end
            endcase
        end
    end

    assign oMemValid     = memValid;
    assign oMemWrite     = memWrite;
    assign oMemAddress   = memAddress;
    assign oMemWriteData = memWriteData;

    // Completion pulses are combinational so the requester sees them in the
    // same cycle the memory completes.
    assign oInstrReady   = (state == StGntI) & iMemReady & ~drop & ~iFlush;
    assign oDataReady    = (state == StGntD) & iMemReady;
    assign oInstrData    = iMemReadData;
    assign oDataReadData = iMemReadData;

endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
Shares one single-port memory between the instruction fetch path and the data load/store path. Both requesters use a valid/ready handshake. Grants are fixed-priority: data wins, except that a starvation counter forces an instruction grant after STARVE_LIMIT consecutive data wins. Supports flushing an in-flight instruction fetch on a branch redirect, and drops the response that arrives for it.

Parameters:
ADDR_WIDTH, 32, memory word-address width
DATA_WIDTH, 32, memory data width
STARVE_LIMIT, 4, maximum consecutive data grants while an instruction request waits (minimum 1)

Ports:
iClk  input  1  clock, rising edge
iRst_n  input  1  asynchronous active-low reset
iInstrValid  input  1  fetch request pending
iInstrAddress  input  ADDR_WIDTH  fetch address
iFlush  input  1  discard the in-flight fetch response (branch/jump/return redirect)
oInstrReady  output  1  fetch complete, one-cycle pulse
oInstrData  output  DATA_WIDTH  fetched word, valid while oInstrReady=1
iDataValid  input  1  load/store request pending
iDataWrite  input  1  1=store, 0=load
iDataAddress  input  ADDR_WIDTH  load/store address
iDataWriteData  input  DATA_WIDTH  store data
oDataReady  output  1  load/store complete, one-cycle pulse
oDataReadData  output  DATA_WIDTH  load data, valid while oDataReady=1
oMemValid  output  1  memory transaction active
oMemWrite  output  1  1=write transaction
oMemAddress  output  ADDR_WIDTH  memory address
oMemWriteData  output  DATA_WIDTH  memory write data
iMemReady  input  1  memory completes the current transaction this cycle
iMemReadData  input  DATA_WIDTH  memory read data, valid with iMemReady

Behaviour:
- Reset (async, iRst_n=0):
  - state=IDLE, starve_cnt=0, drop=0.
  - oMemValid, oMemWrite, oMemAddress, oMemWriteData = 0.
  - oInstrReady, oDataReady = 0.
- Requester contract: hold valid and payload stable until the matching ready pulse. In the cycle after ready, either drop valid or present a new request.
- States: IDLE, GNT_I, GNT_D.
- IDLE, evaluated at the clock edge:
  - If iInstrValid=1 and (iDataValid=0 or starve_cnt==STARVE_LIMIT): go to GNT_I, latch iInstrAddress, latch write=0.
  - Else if iDataValid=1: go to GNT_D, latch address, write and write data.
  - Else: stay in IDLE.
- Counter rules:
  - starve_cnt increments, saturating at STARVE_LIMIT, on each GNT_D entry while iInstrValid=1.
  - starve_cnt clears on GNT_I entry.
- Memory-side outputs are registered from the latched values.
  - oMemValid=1 for the whole of GNT_I/GNT_D; 0 in IDLE.
  - oMemWrite=0 in GNT_I.
  - Arbitration latency is 1 cycle from request valid to oMemValid.
- GNT_x with iMemReady=1:
  - Matching ready output is combinational: oInstrReady = (state==GNT_I) & iMemReady & ~drop & ~iFlush.
  - oDataReady = (state==GNT_D) & iMemReady.
  - Next state is IDLE. There is always one IDLE cycle between transactions.
- GNT_x with iMemReady=0: hold the state and all memory outputs stable (wait states are unbounded).
- oInstrData and oDataReadData are a direct passthrough of iMemReadData.
- Flush:
  - iFlush=1 in GNT_I sets drop=1. The transaction still completes on the memory side, but oInstrReady stays 0.
  - iFlush coincident with iMemReady also suppresses oInstrReady.
  - drop clears on return to IDLE.
  - iFlush in IDLE or GNT_D has no effect.
- A store still completes on the memory side if iFlush is asserted; flush never cancels data transactions.
- Reset mid-transaction:
  - Outputs clear immediately (async).
  - The memory must tolerate abandonment of the orphaned transaction.
  - Requesters re-present their requests after reset.
- With iInstrValid=0, starve_cnt holds its value.

Test Plan:
- Single fetch, iInstrAddress=0x40, memory ready in the first GNT cycle with data 0x12345678 -> oMemValid=1 and oMemAddress=0x40 one cycle after valid; oInstrReady pulses with oInstrData=0x12345678 in that same cycle; IDLE follows.
- iInstrValid and iDataValid asserted together (instr 0x10, data load 0x200) -> GNT_D first with oMemAddress=0x200 and oDataReady, then one IDLE cycle, then GNT_I with 0x10; starve_cnt=1 then 0.
- STARVE_LIMIT=4, iDataValid held high with incrementing addresses, iInstrValid high -> exactly 4 data transactions, 5th grant is GNT_I; data resumes afterwards.
- Fetch 0x80 with 3-cycle memory latency, iFlush pulsed in the 2nd GNT_I cycle -> oInstrReady never asserts, return to IDLE after iMemReady, next fetch 0x90 proceeds normally.
- Store iDataAddress=0x100, iDataWriteData=0xDEADBEEF -> oMemWrite=1 with 0x100/0xDEADBEEF until iMemReady, oDataReady pulses, iFlush ignored.
- Assert iRst_n=0 mid-GNT_D with no clock edge -> oMemValid, oMemWrite, oMemAddress and the ready outputs go to 0 immediately; after release, state is IDLE and starve_cnt=0.
